regfile_sb: RTL

Parametrised integer register file with a scoreboard, the next generation of the core's register file. Two combinational read ports, one write port, an optional write-to-read bypass, and per-register busy bits. The busy bits let the decode stage stall on registers that are still pending from long-latency M-extension ops (div/rem). The block sits between decode/issue and writeback, and replaces the fixed 32x32 file.

---
 rtl/regfile_sb.sv | 117 +++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, one write port and a
// per-register scoreboard that tracks destinations of in-flight long-latency ops.
module regfile_sb #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREG   = 32,
   parameter int unsigned AW     = 5,
   parameter bit          BYPASS = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rs1_val,
   output logic [XLEN-1:0] rs2_val,
   input  logic            reg_write,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] wd,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   output logic            issue_accept,
   output logic            rs1_busy,
   output logic            rs2_busy,
   output logic            hazard,
   output logic [AW:0]     pending_cnt,
   input  logic [AW-1:0]   dbg_sel,
   output logic [XLEN-1:0] dbg_val
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic [AW:0]     pending_cnt_q, pending_cnt_d;

   logic wr_en;
   logic rs1_fwd, rs2_fwd;
   logic rs1_busy_raw, rs2_busy_raw;
   logic waw;
   logic hazard_int;
   logic accept_int;

   // x0 is never written, so it stays at its reset value of zero.
   assign wr_en = reg_write && (rd != '0);

   always_comb begin
      rs1_fwd = reg_write && (rd == rs1) && (rs1 != '0);
      rs2_fwd = reg_write && (rd == rs2) && (rs2 != '0);

      rs1_busy_raw = busy_q[rs1] && (rs1 != '0) && !(BYPASS && reg_write && (rd == rs1));
      rs2_busy_raw = busy_q[rs2] && (rs2 != '0) && !(BYPASS && reg_write && (rd == rs2));

      // A second op may not target a register that is still pending, unless the
      // pending result retires in this very cycle.
      waw = issue_valid && (issue_rd != '0) && busy_q[issue_rd] &&
            !(reg_write && (rd == issue_rd));

      hazard_int = !rst && (rs1_busy_raw || rs2_busy_raw || waw);
      accept_int = !rst && issue_valid && !hazard_int;
   end

   // All outputs are forced to the zero state while reset is held.
   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      dbg_val = '0;
      if (!rst) begin
         rs1_val = (BYPASS && rs1_fwd) ? wd : regs_q[rs1];
         rs2_val = (BYPASS && rs2_fwd) ? wd : regs_q[rs2];
         dbg_val = regs_q[dbg_sel];
      end
   end

   assign rs1_busy     = !rst && rs1_busy_raw;
   assign rs2_busy     = !rst && rs2_busy_raw;
   assign hazard       = hazard_int;
   assign issue_accept = accept_int;
   assign pending_cnt  = pending_cnt_q;

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[rd] = wd;
      end
   end

   // Clear before set so a retire and a re-issue of the same index leaves it busy.
   always_comb begin
      busy_d = busy_q;
      if (wr_en) begin
         busy_d[rd] = 1'b0;
      end
      if (accept_int && (issue_rd != '0)) begin
         busy_d[issue_rd] = 1'b1;
      end
   end

   always_comb begin
      pending_cnt_d = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         pending_cnt_d = pending_cnt_d + {{AW{1'b0}}, busy_d[i]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         busy_q        <= '0;
         pending_cnt_q <= '0;
      end else begin
         regs_q        <= regs_d;
         busy_q        <= busy_d;
         pending_cnt_q <= pending_cnt_d;
      end
   end

endmodule
